// File: rtl/mem_pkg.sv
// Shared constants and state type for the MEM pipeline stage.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-cache request/response port seen from the MEM stage (master) and the cache (slave).
interface memory_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dc_req_valid;
    logic                  dc_req_ready;
    logic                  dc_we;
    logic [DATA_WIDTH-1:0] dc_addr;
    logic [DATA_WIDTH-1:0] dc_wdata;
    logic [3:0]            dc_wstrb;
    logic                  dc_resp_valid;
    logic [DATA_WIDTH-1:0] dc_rdata;

    modport master (
        output dc_req_valid, dc_we, dc_addr, dc_wdata, dc_wstrb,
        input  dc_req_ready, dc_resp_valid, dc_rdata
    );

    modport slave (
        input  dc_req_valid, dc_we, dc_addr, dc_wdata, dc_wstrb,
        output dc_req_ready, dc_resp_valid, dc_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store replication/strobes, load extract/extend, access legality.
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_CTRL_WIDTH = 3
) (
    input  logic [1:0]                i_off,
    input  logic [MEM_CTRL_WIDTH-1:0] i_ctrl,
    input  logic                      i_store,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH-1:0]     i_rdata,
    output logic [DATA_WIDTH-1:0]     o_wdata,
    output logic [3:0]                o_wstrb,
    output logic [DATA_WIDTH-1:0]     o_ldata,
    output logic                      o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_wdata = i_wdata;
        o_wstrb = 4'b0000;
        o_ldata = i_rdata;
        o_err   = 1'b0;
        case (i_ctrl)
            MEM_B: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wstrb = i_store ? (4'b0001 << i_off) : 4'b0000;
                o_ldata = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            end
            MEM_H: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_wstrb = i_store ? (4'b0011 << i_off) : 4'b0000;
                o_ldata = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
                o_err   = i_off[0];
            end
            MEM_W: begin
                o_wstrb = i_store ? 4'b1111 : 4'b0000;
                o_err   = (i_off != 2'b00);
            end
            MEM_BU: begin
                o_ldata = {{(DATA_WIDTH-8){1'b0}}, w_byte};
                o_err   = i_store;
            end
            MEM_HU: begin
                o_ldata = {{(DATA_WIDTH-16){1'b0}}, w_half};
                o_err   = i_store | i_off[0];
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-cache access FSM, stall generation and the M/W pipeline register.
module memory_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 5,
    parameter int SRC_WIDTH       = 2,
    parameter int MEM_CTRL_WIDTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_m,
    input  logic [DATA_WIDTH-1:0]      PCPlus4_m,
    input  logic [DATA_WIDTH-1:0]      ALUResult_m,
    input  logic [DATA_WIDTH-1:0]      WriteData_m,
    input  logic [READ_DATA_WIDTH-1:0] Rd_m,
    input  logic                       RegWrite_m,
    input  logic [SRC_WIDTH-1:0]       ResultSrc_m,
    input  logic                       MemWrite_m,
    input  logic [MEM_CTRL_WIDTH-1:0]  MemCtrl_m,
    output logic                       stall_m,
    memory_stage_if.master             dc,
    output logic                       valid_w,
    output logic [DATA_WIDTH-1:0]      Result_w,
    output logic [READ_DATA_WIDTH-1:0] Rd_w,
    output logic                       RegWrite_w,
    output logic                       mem_err_w
);

    state_t                      r_state;
    logic                        r_valid_w;
    logic [DATA_WIDTH-1:0]       r_result_w;
    logic [READ_DATA_WIDTH-1:0]  r_rd_w;
    logic                        r_regwrite_w;
    logic                        r_mem_err_w;

    logic                        w_mem_op;
    logic                        w_align_err;
    logic                        w_err;
    logic                        w_legal;
    logic                        w_mem_done;
    logic                        w_complete;
    logic [DATA_WIDTH-1:0]       w_st_wdata;
    logic [3:0]                  w_st_wstrb;
    logic [DATA_WIDTH-1:0]       w_ld_data;
    logic [DATA_WIDTH-1:0]       w_result;

    mem_align #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_CTRL_WIDTH(MEM_CTRL_WIDTH)
    ) u_align (
        .i_off  (ALUResult_m[1:0]),
        .i_ctrl (MemCtrl_m),
        .i_store(MemWrite_m),
        .i_wdata(WriteData_m),
        .i_rdata(dc.dc_rdata),
        .o_wdata(w_st_wdata),
        .o_wstrb(w_st_wstrb),
        .o_ldata(w_ld_data),
        .o_err  (w_align_err)
    );

    assign w_mem_op = valid_m & (MemWrite_m | (ResultSrc_m == RES_MEM));
    assign w_err    = w_mem_op & w_align_err;
    assign w_legal  = w_mem_op & ~w_align_err;

    // Stores finish on acceptance; loads finish when the response returns.
    assign w_mem_done = (r_state == IDLE) ? (MemWrite_m & dc.dc_req_ready)
                                          : dc.dc_resp_valid;
    assign w_complete = w_mem_op ? (w_legal & w_mem_done) : valid_m;
    assign stall_m    = w_legal & ~w_mem_done;

    assign dc.dc_req_valid = (r_state == IDLE) & w_legal;
    assign dc.dc_we        = MemWrite_m;
    assign dc.dc_addr      = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};
    assign dc.dc_wdata     = w_st_wdata;
    assign dc.dc_wstrb     = w_st_wstrb;

    always_comb begin
        case (ResultSrc_m)
            RES_MEM: w_result = w_ld_data;
            RES_PC4: w_result = PCPlus4_m;
            default: w_result = ALUResult_m;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid_w    <= 1'b0;
            r_result_w   <= '0;
            r_rd_w       <= '0;
            r_regwrite_w <= 1'b0;
            r_mem_err_w  <= 1'b0;
        end else begin
            case (r_state)
                IDLE:      if (w_legal & ~MemWrite_m & dc.dc_req_ready) r_state <= WAIT_RESP;
                WAIT_RESP: if (dc.dc_resp_valid) r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
            r_mem_err_w <= w_err;
            // Bubbles keep the last data fields; only the qualifiers drop.
            if (w_complete) begin
                r_valid_w    <= 1'b1;
                r_result_w   <= w_result;
                r_rd_w       <= Rd_m;
                r_regwrite_w <= RegWrite_m;
            end else begin
                r_valid_w    <= 1'b0;
                r_regwrite_w <= 1'b0;
            end
        end
    end

    assign valid_w    = r_valid_w;
    assign Result_w   = r_result_w;
    assign Rd_w       = r_rd_w;
    assign RegWrite_w = r_regwrite_w;
    assign mem_err_w  = r_mem_err_w;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed cases then randomized ops against a behavioural model.
module tb_memory_stage;
    import mem_pkg::*;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m;
    logic [31:0] PCPlus4_m, ALUResult_m, WriteData_m;
    logic [4:0]  Rd_m;
    logic        RegWrite_m;
    logic [1:0]  ResultSrc_m;
    logic        MemWrite_m;
    logic [2:0]  MemCtrl_m;
    logic        stall_m;
    logic        valid_w;
    logic [31:0] Result_w;
    logic [4:0]  Rd_w;
    logic        RegWrite_w;
    logic        mem_err_w;

    always #5 clk = ~clk;

    memory_stage_if #(.DATA_WIDTH(DW)) dcif ();

    memory_stage #(
        .DATA_WIDTH(DW), .READ_DATA_WIDTH(5), .SRC_WIDTH(2), .MEM_CTRL_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .PCPlus4_m(PCPlus4_m),
        .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .Rd_m(Rd_m),
        .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .MemWrite_m(MemWrite_m),
        .MemCtrl_m(MemCtrl_m), .stall_m(stall_m), .dc(dcif),
        .valid_w(valid_w), .Result_w(Result_w), .Rd_w(Rd_w),
        .RegWrite_w(RegWrite_w), .mem_err_w(mem_err_w)
    );

    typedef struct {
        bit          err;
        logic [31:0] result;
        logic [4:0]  rd;
        bit          regwrite;
    } wb_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        bit          valid;
        bit          st;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        bit          rw;
        logic [1:0]  rsrc;
    } op_t;

    wb_t  wb_q[$];
    req_t req_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          dir_mode = 1'b1;
    int          lo_cnt = 0;
    int          dir_delay = 1;
    int          resp_cnt = 0;
    logic [31:0] resp_word = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference rules, stated directly in terms of access size and byte offset.
    function automatic bit ref_err(input logic [2:0] ctrl, input bit st, input logic [31:0] a);
        int off = int'(a % 4);
        case (ctrl)
            3'd0:    return 1'b0;
            3'd1:    return (off % 2) != 0;
            3'd2:    return off != 0;
            3'd4:    return st;
            3'd5:    return st || ((off % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ctrl, input logic [31:0] a,
                                             input logic [31:0] word);
        int     off = int'(a % 4);
        longint b   = longint'((word >> (8 * off)) & 32'hFF);
        longint h   = longint'((word >> (16 * (off / 2))) & 32'hFFFF);
        case (ctrl)
            3'd0:    return 32'((b >= 128) ? b - 256 : b);
            3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic req_t ref_req(input op_t op);
        req_t r;
        int   off = int'(op.addr % 4);
        r.we    = op.st;
        r.addr  = op.addr - 32'(off);
        r.wdata = op.wd;
        r.wstrb = 4'b0000;
        if (op.st) begin
            case (op.ctrl)
                3'd0: begin r.wdata = (op.wd & 32'hFF) * 32'h01010101;   r.wstrb = 4'(1 << off); end
                3'd1: begin r.wdata = (op.wd & 32'hFFFF) * 32'h00010001; r.wstrb = 4'(3 << off); end
                default: r.wstrb = 4'hF;
            endcase
        end
        return r;
    endfunction

    function automatic op_t mk(input bit valid, input bit st, input logic [2:0] ctrl,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd, input bit rw, input logic [1:0] rsrc);
        op_t o;
        o.valid = valid; o.st = st; o.ctrl = ctrl; o.addr = addr; o.wd = wd;
        o.pc4 = $urandom(); o.rd = rd; o.rw = rw; o.rsrc = rsrc;
        return o;
    endfunction

    task automatic drive(input op_t op);
        valid_m     = op.valid;
        MemWrite_m  = op.st;
        MemCtrl_m   = op.ctrl;
        ALUResult_m = op.addr;
        WriteData_m = op.wd;
        PCPlus4_m   = op.pc4;
        Rd_m        = op.rd;
        RegWrite_m  = op.rw;
        ResultSrc_m = op.rsrc;
    endtask

    task automatic issue(input op_t op, input logic [31:0] word, output int stalls);
        bit  mem;
        bit  e;
        wb_t w;
        @(posedge clk);
        #2;
        drive(op);
        resp_word = word;
        mem = op.valid && (op.st || op.rsrc == 2'b01);
        e   = mem && ref_err(op.ctrl, op.st, op.addr);
        if (mem && !e) req_q.push_back(ref_req(op));
        if (op.valid) begin
            w.err      = e;
            w.rd       = op.rd;
            w.regwrite = op.rw;
            w.result   = (op.rsrc == 2'b01) ? ref_load(op.ctrl, op.addr, word) :
                         (op.rsrc == 2'b10) ? op.pc4 : op.addr;
            wb_q.push_back(w);
        end
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall_m) break;
            stalls++;
            if (stalls > 64) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout actual=%0d cycles required=<=64", stalls);
                break;
            end
        end
    endtask

    // Cache model: checks every presented request, then schedules handshake/response.
    initial begin
        req_t r;
        bit   real_resp;
        dcif.dc_req_ready  = 1'b0;
        dcif.dc_resp_valid = 1'b0;
        dcif.dc_rdata      = '0;
        forever begin
            @(negedge clk);
            if (dcif.dc_req_valid === 1'b1) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=addr %h required=no request", dcif.dc_addr);
                end else begin
                    r = req_q[0];
                    chk("req_we", 32'(dcif.dc_we), 32'(r.we));
                    chk("req_addr", dcif.dc_addr, r.addr);
                    chk("req_wstrb", 32'(dcif.dc_wstrb), 32'(r.wstrb));
                    if (r.we) chk("req_wdata", dcif.dc_wdata, r.wdata);
                    if (dcif.dc_req_ready) begin
                        void'(req_q.pop_front());
                        if (!r.we) resp_cnt = dir_mode ? dir_delay : int'($urandom_range(1, 4));
                    end else if (lo_cnt > 0) begin
                        lo_cnt--;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst) resp_cnt = 0;
            dcif.dc_req_ready = dir_mode ? (lo_cnt == 0) : ($urandom_range(0, 2) != 0);
            real_resp = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                real_resp = (resp_cnt == 0);
                dcif.dc_resp_valid = real_resp;
            end else begin
                dcif.dc_resp_valid = !dir_mode && ($urandom_range(0, 7) == 0);
            end
            dcif.dc_rdata = real_resp ? resp_word : $urandom();
        end
    end

    // Writeback monitor.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (valid_w || mem_err_w) begin
                    if (wb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wb actual=valid %b err %b required=none", valid_w, mem_err_w);
                    end else begin
                        w = wb_q.pop_front();
                        if (w.err) begin
                            chk("wb_err_flag", 32'(mem_err_w), 32'd1);
                            chk("wb_err_valid", 32'(valid_w), 32'd0);
                        end else begin
                            chk("wb_valid", 32'(valid_w), 32'd1);
                            chk("wb_noerr", 32'(mem_err_w), 32'd0);
                            chk("wb_result", Result_w, w.result);
                            chk("wb_rd", 32'(Rd_w), 32'(w.rd));
                            chk("wb_regwrite", 32'(RegWrite_w), 32'(w.regwrite));
                        end
                    end
                end else begin
                    chk("bubble_regwrite", 32'(RegWrite_w), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          k;
        op_t         op;
        logic [31:0] rnd;
        logic [2:0]  ctrls [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst = 1'b1;
        drive(mk(1'b0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 2'b00));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_w", 32'(valid_w), 32'd0);
        chk("rst_result_w", Result_w, 32'd0);
        chk("rst_rd_w", 32'(Rd_w), 32'd0);
        chk("rst_regwrite_w", 32'(RegWrite_w), 32'd0);
        chk("rst_mem_err_w", 32'(mem_err_w), 32'd0);
        chk("rst_stall_m", 32'(stall_m), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        issue(mk(1'b1, 1'b0, 3'd2, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00), 32'h0, st);
        chk("alu_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b0, 3'd2, 32'h55AA, 32'h0, 5'd7, 1'b1, 2'b10), 32'h0, st);
        chk("pc4_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b1, 3'd0, 32'h103, 32'hAB, 5'd0, 1'b0, 2'b00), 32'h0, st);
        chk("sb_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b1, 3'd1, 32'h206, 32'h1234BEEF, 5'd0, 1'b0, 2'b00), 32'h0, st);
        chk("sh_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b1, 3'd2, 32'h308, 32'hCAFEF00D, 5'd0, 1'b0, 2'b00), 32'h0, st);
        chk("sw_stall", 32'(st), 32'd0);
        dir_delay = 3;
        issue(mk(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 5'd9, 1'b1, 2'b01), 32'h00800000, st);
        chk("lb_stall", 32'(st), 32'd3);
        issue(mk(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd10, 1'b1, 2'b01), 32'h00800000, st);
        chk("lbu_stall", 32'(st), 32'd3);
        dir_delay = 1;
        issue(mk(1'b1, 1'b0, 3'd1, 32'h402, 32'h0, 5'd11, 1'b1, 2'b01), 32'h9ABC1234, st);
        chk("lh_stall", 32'(st), 32'd1);
        lo_cnt = 2;
        issue(mk(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd12, 1'b1, 2'b01), 32'h87654321, st);
        chk("lw_ready_low_stall", 32'(st), 32'd3);
        issue(mk(1'b1, 1'b0, 3'd2, 32'h202, 32'h0, 5'd13, 1'b1, 2'b01), 32'h0, st);
        chk("lw_misalign_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 5'd14, 1'b1, 2'b01), 32'h0, st);
        chk("illegal_ctrl_stall", 32'(st), 32'd0);
        issue(mk(1'b1, 1'b1, 3'd4, 32'h200, 32'h0, 5'd0, 1'b0, 2'b00), 32'h0, st);
        chk("store_bu_stall", 32'(st), 32'd0);

        // Reset while a load waits for its response.
        dir_delay = 8;
        @(posedge clk);
        #2;
        op = mk(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 5'd15, 1'b1, 2'b01);
        drive(op);
        req_q.push_back(ref_req(op));
        @(negedge clk);
        chk("rst_mid_stall_before", 32'(stall_m), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        valid_m = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid_w", 32'(valid_w), 32'd0);
        chk("rst_mid_stall_m", 32'(stall_m), 32'd0);
        chk("rst_mid_req_valid", 32'(dcif.dc_req_valid), 32'd0);
        dir_delay = 1;
        issue(mk(1'b1, 1'b0, 3'd2, 32'hBEEF, 32'h0, 5'd3, 1'b1, 2'b00), 32'h0, st);
        chk("post_rst_alu_stall", 32'(st), 32'd0);

        // Randomized traffic.
        dir_mode = 1'b0;
        for (int n = 0; n < 400; n++) begin
            k   = int'($urandom_range(0, 9));
            rnd = $urandom();
            op  = mk(k != 0, 1'b0, ctrls[$urandom_range(0, 4)],
                     {rnd[31:2], ($urandom_range(0, 1) != 0) ? 2'b00 : rnd[1:0]},
                     $urandom(), 5'($urandom_range(0, 31)), $urandom_range(0, 1) != 0,
                     2'b00);
            if ($urandom_range(0, 5) == 0) op.ctrl = 3'($urandom_range(0, 7));
            if (k >= 1 && k <= 3) begin
                rnd = $urandom();
                op.rsrc = (rnd[1:0] == 2'b01) ? 2'b00 : rnd[1:0];
            end else if (k >= 4 && k <= 6) begin
                op.rsrc = 2'b01;
            end else if (k >= 7) begin
                op.st = 1'b1;
                op.rsrc = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            end
            issue(op, $urandom(), st);
        end

        @(posedge clk);
        #2;
        valid_m = 1'b0;
        repeat (10) @(negedge clk);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Consumes the E/M pipeline register outputs (valid_m, PCPlus4_m, ALUResult_m, WriteData_m, Rd_m, RegWrite_m, ResultSrc_m, MemWrite_m, MemCtrl_m).
- Performs loads and stores through a valid/ready data-cache port.
- Aligns store data and sign- or zero-extends load data.
- Raises stall_m while a cache access is in flight.
- Contains the M/W pipeline register that feeds writeback.

Parameters:
- DATA_WIDTH, 32, datapath and address width.
- READ_DATA_WIDTH, 5, register index width.
- SRC_WIDTH, 2, ResultSrc width.
- MEM_CTRL_WIDTH, 3, MemCtrl width (RISC-V funct3 encoding).

Ports:
- clk  in  1  clock; rising-edge active.
- rst  in  1  reset; synchronous, active-high.
- valid_m  in  1  instruction in MEM is valid.
- PCPlus4_m  in  DATA_WIDTH  PC+4.
- ALUResult_m  in  DATA_WIDTH  ALU result / byte address.
- WriteData_m  in  DATA_WIDTH  store source data.
- Rd_m  in  READ_DATA_WIDTH  destination register.
- RegWrite_m  in  1  register write enable.
- ResultSrc_m  in  SRC_WIDTH  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- MemWrite_m  in  1  store.
- MemCtrl_m  in  MEM_CTRL_WIDTH  000 B, 001 H, 010 W, 100 BU, 101 HU.
- stall_m  out  1  hold E/M register and all earlier stages.
- dc_req_valid  out  1  cache request valid.
- dc_req_ready  in  1  cache accepts request.
- dc_we  out  1  request is a store.
- dc_addr  out  DATA_WIDTH  word address, ALUResult_m with bits [1:0] cleared.
- dc_wdata  out  DATA_WIDTH  store data, replicated per lane.
- dc_wstrb  out  4  byte strobes.
- dc_resp_valid  in  1  load data valid.
- dc_rdata  in  DATA_WIDTH  load word.
- valid_w  out  1  writeback instruction valid.
- Result_w  out  DATA_WIDTH  writeback value.
- Rd_w  out  READ_DATA_WIDTH  writeback destination.
- RegWrite_w  out  1  writeback enable.
- mem_err_w  out  1  one-cycle pulse on misaligned or illegal access.

Behaviour:
- Memory op means valid_m AND (MemWrite_m OR ResultSrc_m==01).
- Reset (rst=1 at a clk edge): state=IDLE; valid_w, Result_w, Rd_w, RegWrite_w and mem_err_w all 0.
- The cache shares rst, so no stale response survives a reset. A reset mid-access abandons the access.
- Error check runs before any cache request is issued:
  - H with addr[0]=1, or W with addr[1:0]!=0, is an error.
  - MemCtrl 011/110/111 is an error, and so is BU/HU used with a store.
  - An error issues no request and stalls 0 cycles.
  - Next cycle: valid_w=0, mem_err_w=1.
- FSM has two states:
  - IDLE: dc_req_valid = legal memory op (combinational).
    - Store accepted (dc_req_ready=1): completes this cycle, no stall.
    - Load accepted: go to WAIT_RESP.
    - ready=0: stay in IDLE. Request fields stay stable because upstream is stalled.
  - WAIT_RESP: dc_req_valid=0.
    - On dc_resp_valid: complete and go to IDLE.
    - A response never arrives in the same cycle as its acceptance.
- stall_m = memory op AND NOT completing this cycle. Best case: load stalls 1 cycle, store 0 cycles.
- dc_resp_valid is ignored in IDLE.
- Store formatting, off = addr[1:0]:
  - SB: wdata = {4{byte}}, wstrb = 0001<<off.
  - SH: wdata = {2{half}}, wstrb = 0011<<off.
  - SW: wstrb = 1111.
  - Loads drive wstrb=0.
- Load formatting: select rdata[8*off +: 8] or rdata[16*off[1] +: 16], then sign-extend (B/H) or zero-extend (BU/HU). LW passes the word through.
- M/W register updates every cycle:
  - Valid completion (memory op done, or valid non-memory op): valid_w=1; Result_w per ResultSrc; Rd_w and RegWrite_w copied from the M stage.
  - Otherwise valid_w=0 and RegWrite_w=0 (bubble). Other fields hold.
- Writeback never stalls this stage.

Decomposition:
- Shared package mem_pkg holds:
  - MemCtrl constants MEM_B/H/W/BU/HU.
  - ResultSrc constants RES_ALU/RES_MEM/RES_PC4.
  - FSM state enum {IDLE, WAIT_RESP}.
- One combinational sub-module, mem_align: store lane and strobe generation, load extraction and extension, misalign/illegal detection.
- The FSM and M/W register stay in memory_stage.

Test Plan:
- ALU op, ALUResult_m=0x1234, ResultSrc=00, RegWrite=1, Rd=5 -> stall_m=0; next cycle valid_w=1, Result_w=0x1234, Rd_w=5.
- SB addr=0x103, data=0xAB, ready=1 -> dc_we=1, dc_addr=0x100, wstrb=1000, wdata=0xABABABAB; stall_m=0; valid_w=1 next cycle.
- LB addr=0x102, ready=1, response 3 cycles later with rdata=0x00800000 -> stall_m high 3 cycles; Result_w=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LW addr=0x200 with ready=0 for 2 cycles -> dc_req_valid held with dc_addr stable; stall_m=1 throughout.
- LW addr=0x202 -> no dc_req_valid; stall_m=0; next cycle mem_err_w=1, valid_w=0. MemCtrl=011 gives the same result.
- rst=1 during WAIT_RESP -> next cycle state=IDLE, valid_w=0, stall_m=0; the following ALU op completes normally.
